code_lock_ctrl: RTL and testbench

//  Parametrised keypad code lock: N debounced active-low keys, CODE_LEN-digit code, runtime reprogramming,

---
 rtl/code_lock_pkg.sv | 26 ++
 rtl/code_lock_ctrl_key_debounce.sv | 24 ++
 rtl/code_lock_ctrl.sv | 124 ++++++++++++
 tb/tb_code_lock_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: state encoding, width helpers and beep pattern constants for the code lock
package code_lock_pkg;
   typedef enum logic [2:0] {
      S_LOCKED   = 3'd0,
      S_ENTRY    = 3'd1,
      S_CHECK    = 3'd2,
      S_UNLOCKED = 3'd3,
      S_FAIL     = 3'd4,
      S_LOCKOUT  = 3'd5,
      S_PROG     = 3'd6
   } state_t;
   localparam int ONE_BEEP_PH = 1;
   localparam int TWO_BEEP_PH = 3;
   function automatic int kw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cw(input int len);
      return $clog2(len + 1);
   endfunction
   function automatic int fw(input int m);
      return $clog2(m + 1);
   endfunction
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/code_lock_ctrl_key_debounce.sv
// key_debounce: synchronises one active-low key and emits a single pulse per stable press
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic key,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   logic [1:0]    sync;
   logic [DW-1:0] cnt;
   // count stable-low cycles after the synchroniser; pulse once when the count completes
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sync  <= 2'b11;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         cnt   <= sync[1] ? '0 : cnt + DW'(cnt != DW'(DEBOUNCE_CYC));
         press <= !sync[1] && cnt == DW'(DEBOUNCE_CYC - 1);
      end
endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code lock with reprogramming, failure lockout, timeouts and beep feedback
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int CODE_LEN     = 4,
   parameter logic [CODE_LEN*kw(NUM_KEYS)-1:0] DEFAULT_CODE = 8'hE4,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int TIMEOUT_CYC  = 250_000_000,
   parameter int RELOCK_CYC   = 500_000_000,
   parameter int MAX_FAIL     = 3,
   parameter int LOCKOUT_CYC  = 1_500_000_000,
   parameter int BEEP_CYC     = 5_000_000
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_KEYS-1:0]       key,
   input  logic                      prog_en,
   output logic                      unlocked,
   output logic                      locked_out,
   output logic [cw(CODE_LEN)-1:0]   progress,
   output logic [fw(MAX_FAIL)-1:0]   fail_cnt,
   output logic [2:0]                state_o,
   output logic                      beep
);
   localparam int KW   = kw(NUM_KEYS);
   localparam int CW   = cw(CODE_LEN);
   localparam int FW   = fw(MAX_FAIL);
   localparam int TW   = $clog2(max3(TIMEOUT_CYC, RELOCK_CYC, LOCKOUT_CYC) + 1);
   localparam int BMAX = TWO_BEEP_PH * BEEP_CYC;
   localparam int BW   = $clog2(BMAX + 1);
   state_t                 state, state_nx;
   logic [NUM_KEYS-1:0]    press;
   logic [KW-1:0]          digit, cur;
   logic [CODE_LEN*KW-1:0] code, shadow, shadow_nx;
   logic [TW-1:0]          tmr, tmr_load;
   logic [BW-1:0]          bcnt;
   logic any, multi, last, take, keep, commit, tmr_done, mismatch, chime, prog_blk;
   genvar g;
   for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .clk   (clk),
         .rstn  (rstn),
         .key   (key[g]),
         .press (press[g])
      );
   end
   assign any      = |press;
   assign multi    = |(press & (press - NUM_KEYS'(1)));
   assign last     = progress == CW'(CODE_LEN - 1);
   assign tmr_done = tmr == '0;
   assign take     = any && (state == S_LOCKED || state == S_ENTRY || state == S_PROG);
   assign commit   = state == S_PROG && any && last && prog_en && !tmr_done;
   assign keep     = state_nx inside {S_ENTRY, S_CHECK, S_PROG};
   assign tmr_load = (state_nx == S_UNLOCKED) ? TW'(RELOCK_CYC - 1) :
                     (state_nx == S_LOCKOUT)  ? TW'(LOCKOUT_CYC - 1) : TW'(TIMEOUT_CYC - 1);
   // lowest pressed key gives the digit; also select the stored digit and build the next shadow code
   always_comb begin
      digit     = '0;
      cur       = '0;
      shadow_nx = shadow;
      for (int j = NUM_KEYS - 1; j >= 0; j--) if (press[j]) digit = KW'(j);
      for (int j = 0; j < CODE_LEN; j++) if (progress == CW'(j)) begin
         cur                       = code[j*KW +: KW];
         shadow_nx[j*KW +: KW]     = digit;
      end
   end
   // state register
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= S_LOCKED;
      else state <= state_nx;
   // next state and status outputs; timeouts win over presses
   always_comb begin
      state_nx   = state;
      unlocked   = state == S_UNLOCKED || state == S_PROG;
      locked_out = state == S_LOCKOUT;
      state_o    = state;
      beep       = (state == S_LOCKOUT) ||
                   (state == S_FAIL && (bcnt < BW'(ONE_BEEP_PH * BEEP_CYC) || bcnt >= BW'(BMAX - BEEP_CYC))) ||
                   (state == S_UNLOCKED && chime && bcnt < BW'(ONE_BEEP_PH * BEEP_CYC));
      case (state)
         S_LOCKED:   if (any) state_nx = last ? S_CHECK : S_ENTRY;
         S_ENTRY:    if (tmr_done) state_nx = S_LOCKED; else if (any && last) state_nx = S_CHECK;
         S_CHECK:    state_nx = mismatch ? S_FAIL : S_UNLOCKED;
         S_FAIL:     if (bcnt == BW'(BMAX - 1)) state_nx = (fail_cnt == FW'(MAX_FAIL)) ? S_LOCKOUT : S_LOCKED;
         S_LOCKOUT:  if (tmr_done) state_nx = S_LOCKED;
         S_UNLOCKED: if (tmr_done || any) state_nx = S_LOCKED; else if (prog_en && !prog_blk) state_nx = S_PROG;
         S_PROG:     if (tmr_done || !prog_en || (any && last)) state_nx = S_UNLOCKED;
         default:    state_nx = S_LOCKED;
      endcase
   end
   // shared timer reloads on state entry and accepted digits; beep sequencer restarts on every entry
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         tmr   <= '0;
         bcnt  <= '0;
         chime <= 1'b0;
      end else if (state_nx != state) begin
         tmr   <= tmr_load;
         bcnt  <= '0;
         chime <= state_nx == S_UNLOCKED && (state == S_CHECK || commit);
      end else begin
         tmr   <= take ? tmr_load : tmr - TW'(!tmr_done);
         bcnt  <= bcnt + BW'(bcnt != BW'(BMAX));
      end
   // attempt progress, sticky mismatch, failure count, code and shadow registers
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         progress <= '0;
         mismatch <= 1'b0;
         fail_cnt <= '0;
         code     <= DEFAULT_CODE;
         shadow   <= '0;
         prog_blk <= 1'b0;
      end else begin
         progress <= keep ? progress + CW'(take) : '0;
         if (take && state != S_PROG) mismatch <= (mismatch && state == S_ENTRY) || multi || digit != cur;
         if (take && state == S_PROG) shadow <= shadow_nx;
         if (commit) code <= shadow_nx;
         if (state == S_CHECK) fail_cnt <= !mismatch ? '0 : fail_cnt + FW'(fail_cnt != FW'(MAX_FAIL));
         else if (state == S_LOCKOUT && state_nx == S_LOCKED) fail_cnt <= '0;
         prog_blk <= (state == S_PROG && state_nx != S_PROG) || (prog_blk && prog_en);
      end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed self-checking bench for the code lock with short sim timings
module tb_code_lock_ctrl;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       prog_en = 1'b0;
   logic [3:0] key = 4'hF;
   logic       unlocked, locked_out, beep;
   logic [2:0] progress;
   logic [1:0] fail_cnt;
   logic [2:0] state_o;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   code_lock_ctrl #(
      .NUM_KEYS(4), .CODE_LEN(4), .DEFAULT_CODE(8'hE4), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(50),
      .RELOCK_CYC(80), .MAX_FAIL(3), .LOCKOUT_CYC(100), .BEEP_CYC(3)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .key        (key),
      .prog_en    (prog_en),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .progress   (progress),
      .fail_cnt   (fail_cnt),
      .state_o    (state_o),
      .beep       (beep)
   );
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic push(input int k);
      key[k] = 1'b0;
      tick(8);
      key[k] = 1'b1;
      tick(8);
   endtask
   task automatic enter(input int a, input int b, input int c, input int d);
      push(a); push(b); push(c); push(d);
   endtask
   initial begin
      tick(3);
      chk("rst_state", state_o, 0);
      chk("rst_unlocked", unlocked, 0);
      chk("rst_locked_out", locked_out, 0);
      chk("rst_progress", progress, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_beep", beep, 0);
      rstn = 1'b1;
      tick(2);
      push(0);
      chk("entry_state", state_o, 1);
      chk("entry_prog1", progress, 1);
      push(1);
      push(2);
      chk("entry_prog3", progress, 3);
      key[3] = 1'b0;
      tick(6);
      chk("pre_check_state", state_o, 1);
      tick(1);
      chk("check_state", state_o, 2);
      chk("check_progress", progress, 4);
      tick(1);
      chk("ok_state", state_o, 3);
      chk("ok_unlocked", unlocked, 1);
      chk("ok_beep_first", beep, 1);
      chk("ok_progress", progress, 0);
      chk("ok_fail", fail_cnt, 0);
      tick(2);
      chk("ok_beep_third", beep, 1);
      tick(1);
      chk("ok_beep_off", beep, 0);
      key[3] = 1'b1;
      tick(8);
      push(0);
      chk("manual_lock", state_o, 0);
      chk("manual_lock_unl", unlocked, 0);
      key[0] = 1'b0; tick(2); key[0] = 1'b1; tick(1); key[0] = 1'b0; tick(6); key[0] = 1'b1; tick(8);
      chk("bounce_state", state_o, 1);
      chk("bounce_one_press", progress, 1);
      tick(50);
      chk("bounce_timeout", state_o, 0);
      chk("bounce_timeout_prog", progress, 0);
      key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(10);
      chk("glitch_state", state_o, 0);
      chk("glitch_prog", progress, 0);
      push(0);
      push(1);
      chk("idle_prog2", progress, 2);
      tick(40);
      chk("idle_before_to", state_o, 1);
      tick(1);
      chk("idle_timeout", state_o, 0);
      chk("idle_timeout_prog", progress, 0);
      chk("idle_timeout_fail", fail_cnt, 0);
      for (int k = 1; k <= 3; k++) begin
         push(0); push(2); push(2);
         key[3] = 1'b0;
         tick(8);
         chk("fail_state", state_o, 4);
         chk("fail_cnt", fail_cnt, k);
         chk("fail_beep1", beep, 1);
         key[3] = 1'b1;
         tick(3);
         chk("fail_beep_gap", beep, 0);
         tick(3);
         chk("fail_beep2", beep, 1);
         tick(2);
         chk("fail_hold", state_o, 4);
         tick(1);
         chk("fail_exit", state_o, (k == 3) ? 5 : 0);
         chk("fail_exit_lo", locked_out, (k == 3) ? 1 : 0);
      end
      push(1);
      chk("lockout_ignores", state_o, 5);
      chk("lockout_prog", progress, 0);
      chk("lockout_beep", beep, 1);
      tick(83);
      chk("lockout_hold", locked_out, 1);
      chk("lockout_fail", fail_cnt, 3);
      tick(1);
      chk("lockout_end", state_o, 0);
      chk("lockout_end_lo", locked_out, 0);
      chk("lockout_end_fail", fail_cnt, 0);
      chk("lockout_end_beep", beep, 0);
      enter(0, 1, 2, 3);
      chk("relock_unl", state_o, 3);
      tick(71);
      chk("relock_hold", state_o, 3);
      tick(1);
      chk("relock_fire", state_o, 0);
      enter(0, 1, 2, 3);
      prog_en = 1'b1;
      tick(2);
      chk("prog_state", state_o, 6);
      chk("prog_unlocked", unlocked, 1);
      push(3); push(3); push(1);
      chk("prog_progress", progress, 3);
      key[0] = 1'b0;
      tick(7);
      chk("prog_commit", state_o, 3);
      chk("prog_commit_beep", beep, 1);
      chk("prog_commit_prog", progress, 0);
      key[0] = 1'b1;
      tick(8);
      chk("prog_no_reentry", state_o, 3);
      prog_en = 1'b0;
      tick(2);
      push(2);
      chk("prog_lock", state_o, 0);
      enter(0, 1, 2, 3);
      chk("old_code_fail", state_o, 4);
      chk("old_code_cnt", fail_cnt, 1);
      tick(1);
      chk("old_code_locked", state_o, 0);
      enter(3, 3, 1, 0);
      chk("new_code_ok", state_o, 3);
      chk("new_code_fail", fail_cnt, 0);
      rstn = 1'b0;
      tick(1);
      chk("mid_rst_state", state_o, 0);
      chk("mid_rst_unl", unlocked, 0);
      rstn = 1'b1;
      tick(2);
      enter(0, 1, 2, 3);
      chk("default_restored", state_o, 3);
      push(0);
      chk("relocked", state_o, 0);
      key[0] = 1'b0; key[1] = 1'b0;
      tick(8);
      key = 4'hF;
      tick(8);
      chk("multi_state", state_o, 1);
      chk("multi_one_digit", progress, 1);
      push(1); push(2); push(3);
      chk("multi_fail", state_o, 4);
      chk("multi_fail_cnt", fail_cnt, 1);
      tick(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
